fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 12 +
 rtl/sat_counter.sv | 19 +
 rtl/fetch_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch controller
package fetch_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC sequencer with redirect/flush handling
// Statistics counters are built only when FETCH_CTRL_STATS_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        mispredict,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  output logic        flush_out,
  output logic        misalign_err,
  output logic [31:0] fetch_count,
  output logic [15:0] redirect_count
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [2:0]      flush_cnt, flush_cnt_nxt;
  logic            misalign_q, misalign_nxt;
  logic            advance;

  assign advance = fetch_valid && fetch_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      flush_cnt  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      flush_cnt  <= flush_cnt_nxt;
      misalign_q <= misalign_nxt;
    end
  end

  // A redirect wins over everything else and may arrive in any state.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    flush_cnt_nxt = flush_cnt;
    misalign_nxt  = 1'b0;
    if (mispredict) begin
      state_nxt     = FLUSH;
      pc_nxt        = {redirect_pc[31:2], 2'b00};
      flush_cnt_nxt = FLUSH_INIT;
      misalign_nxt  = |redirect_pc[1:0];
    end else begin
      case (state)
        IDLE: state_nxt = RUN;
        RUN: begin
          if (advance) pc_nxt = pc + PC_W'(INSTR_BYTES);
        end
        FLUSH: begin
          if (flush_cnt <= 3'd1) begin
            state_nxt     = RUN;
            flush_cnt_nxt = '0;
          end else begin
            flush_cnt_nxt = flush_cnt - 3'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    fetch_valid = 1'b0;
    flush_out   = 1'b0;
    if (state == RUN)   fetch_valid = !stall;
    if (state == FLUSH) flush_out   = 1'b1;
  end

  assign pc_out       = pc;
  assign misalign_err = misalign_q;

`ifdef FETCH_CTRL_STATS_EN
  sat_counter #(.WIDTH(32)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (advance),
    .count (fetch_count)
  );

  sat_counter #(.WIDTH(16)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mispredict),
    .count (redirect_count)
  );
`else
  assign fetch_count    = '0;
  assign redirect_count = '0;
`endif

endmodule
